// File: rtl/automata_stage_rc_pkg.sv
// Shared definitions for the automata stage report collector.
// Holds default parameter values, a width helper, and the default event entry layout.
// Imported by the interface, the event FIFO and the top module.
package automata_stage_pkg;

   localparam int DEF_SYM_W       = 8;
   localparam int DEF_NUM_REPORTS = 36;
   localparam int DEF_PIPE_DEPTH  = 1;
   localparam int DEF_FIFO_DEPTH  = 8;
   localparam int DEF_CYC_W       = 32;
   localparam int DEF_DROP_W      = 16;

   // Bits needed to index 'value' items; never returns less than 1 so that
   // single-entry structures still get a legal vector width.
   function automatic int clog2_safe(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Event entry at default widths. Instances with non-default widths build
   // the same {cyc, reports} layout locally from their own parameters.
   typedef struct packed {
      logic [DEF_CYC_W-1:0]       cyc;
      logic [DEF_NUM_REPORTS-1:0] reports;
   } evt_entry_t;

endpackage

// File: rtl/automata_stage_rc_if.sv
// Event drain handshake of the stage report collector.
// Ports: evt_valid/evt_cycle/evt_reports driven by the stage (master), evt_ready by the consumer (slave).
// Payload is held stable by the master while evt_valid=1 and evt_ready=0.
interface automata_stage_rc_if
   import automata_stage_pkg::*;
#(
   parameter int CYC_W       = DEF_CYC_W,
   parameter int NUM_REPORTS = DEF_NUM_REPORTS
);
   logic                   evt_valid;
   logic                   evt_ready;
   logic [CYC_W-1:0]       evt_cycle;
   logic [NUM_REPORTS-1:0] evt_reports;

   modport master (output evt_valid, output evt_cycle, output evt_reports, input evt_ready);
   modport slave  (input evt_valid, input evt_cycle, input evt_reports, output evt_ready);
endinterface

// File: rtl/automata_stage_rc_fifo.sv
// Synchronous FIFO for report events; dout shows the head entry straight from storage.
// Ports: clk/reset, push/din write side, pop/dout read side, full/empty/count status.
// A push while full is accepted only together with a pop; a pop while empty is ignored.
module report_evt_fifo
   import automata_stage_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int CNT_W = clog2_safe(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   localparam int AW = clog2_safe(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr];

   // Storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/automata_stage_rc.sv
// Cluster stage wrapper: forwards symbols/reset down the chain and collects time-stamped report events.
// Ports: clk/reset, run, in_symbols/in_reports in; out_symbols/out_reset forwarded; evt (master) drains
// events; clear_sticky, sticky_reports, overflow, drop_count for diagnosis. All outputs are registered.
module automata_stage_rc
   import automata_stage_pkg::*;
#(
   parameter int SYM_W       = DEF_SYM_W,
   parameter int NUM_REPORTS = DEF_NUM_REPORTS,
   parameter int PIPE_DEPTH  = DEF_PIPE_DEPTH,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int CYC_W       = DEF_CYC_W,
   parameter int DROP_W      = DEF_DROP_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic [SYM_W-1:0]       in_symbols,
   input  logic [NUM_REPORTS-1:0] in_reports,
   output logic [SYM_W-1:0]       out_symbols,
   output logic                   out_reset,
   input  logic                   clear_sticky,
   automata_stage_rc_if.master    evt,
   output logic [NUM_REPORTS-1:0] sticky_reports,
   output logic                   overflow,
   output logic [DROP_W-1:0]      drop_count
);
   localparam int CNT_W = clog2_safe(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [CYC_W-1:0]       cyc;
      logic [NUM_REPORTS-1:0] reports;
   } entry_t;

   logic [SYM_W-1:0]      sym_pipe [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0] rst_pipe;
   logic [CYC_W-1:0]      cyc_cnt;
   entry_t                push_entry;
   entry_t                head_entry;
   logic                  push;
   logic                  pop;
   logic                  drop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      fifo_count;

   // Reset forwarding is deliberately not reset itself: the next stage must
   // see the reset pulse delayed, not a pipeline forced to zero.
   always_ff @(posedge clk) begin
      rst_pipe[0] <= reset;
      for (int k = 1; k < PIPE_DEPTH; k++) rst_pipe[k] <= rst_pipe[k-1];
   end
   assign out_reset = rst_pipe[PIPE_DEPTH-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < PIPE_DEPTH; k++) sym_pipe[k] <= '0;
      end else if (run) begin
         sym_pipe[0] <= in_symbols;
         for (int k = 1; k < PIPE_DEPTH; k++) sym_pipe[k] <= sym_pipe[k-1];
      end
   end
   assign out_symbols = sym_pipe[PIPE_DEPTH-1];

   // Counter value before the edge is the stamp of the sample taken at that edge.
   always_ff @(posedge clk) begin
      if (reset)    cyc_cnt <= '0;
      else if (run) cyc_cnt <= cyc_cnt + CYC_W'(1);
   end

   assign push       = run && (|in_reports) && !reset;
   assign pop        = !fifo_empty && evt.evt_ready;
   assign drop       = push && fifo_full && !pop;
   assign push_entry = '{cyc: cyc_cnt, reports: in_reports};

   report_evt_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (push_entry),
      .pop   (pop),
      .dout  (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign evt.evt_valid   = !fifo_empty;
   assign evt.evt_cycle   = head_entry.cyc;
   assign evt.evt_reports = head_entry.reports;

   // A report or drop arriving together with clear_sticky survives the clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         sticky_reports <= '0;
         overflow       <= 1'b0;
         drop_count     <= '0;
      end else if (clear_sticky) begin
         sticky_reports <= run ? in_reports : '0;
         overflow       <= drop;
         drop_count     <= drop ? DROP_W'(1) : '0;
      end else begin
         if (run) sticky_reports <= sticky_reports | in_reports;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
         end
      end
   end

   a_empty_matches_count: assert property (@(posedge clk) disable iff (reset)
      fifo_empty == (fifo_count == '0));
endmodule

// File: tb/tb_automata_stage_rc.sv
module tb_automata_stage_rc;
   logic        clk;
   logic        reset;
   logic        run;
   logic [7:0]  in_symbols;
   logic [35:0] in_reports;
   logic [7:0]  out_symbols;
   logic        out_reset;
   logic        clear_sticky;
   logic [35:0] sticky_reports;
   logic        overflow;
   logic [1:0]  drop_count;

   int n_checks = 0;
   int n_fail   = 0;

   automata_stage_rc_if #(.CYC_W(4), .NUM_REPORTS(36)) evt_if ();

   automata_stage_rc #(
      .SYM_W(8), .NUM_REPORTS(36), .PIPE_DEPTH(2),
      .FIFO_DEPTH(4), .CYC_W(4), .DROP_W(2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .run            (run),
      .in_symbols     (in_symbols),
      .in_reports     (in_reports),
      .out_symbols    (out_symbols),
      .out_reset      (out_reset),
      .clear_sticky   (clear_sticky),
      .evt            (evt_if),
      .sticky_reports (sticky_reports),
      .overflow       (overflow),
      .drop_count     (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int wrap_exp [5];
      int tail_exp [3];
      wrap_exp = '{12, 13, 14, 15, 0};
      tail_exp = '{8, 9, 10};

      reset = 1'b1; run = 1'b0; in_symbols = 8'h00; in_reports = '0;
      clear_sticky = 1'b0; evt_if.evt_ready = 1'b0;
      tick(); tick();
      chk("rst_out_symbols", out_symbols, 0);
      chk("rst_evt_valid", evt_if.evt_valid, 0);
      chk("rst_sticky", sticky_reports, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_drop_count", drop_count, 0);
      chk("rst_out_reset", out_reset, 1);

      reset = 1'b0;
      tick(); chk("rst_fwd_tail1", out_reset, 1);
      tick(); chk("rst_fwd_tail0", out_reset, 0);

      // Symbol pipeline, depth 2
      run = 1'b1; in_symbols = 8'h11;
      tick(); chk("pipe_edge1", out_symbols, 8'h00);
      in_symbols = 8'h22;
      tick(); chk("pipe_edge2", out_symbols, 8'h11);
      in_symbols = 8'h33;
      tick(); chk("pipe_edge3", out_symbols, 8'h22);
      run = 1'b0; in_symbols = 8'h44;
      repeat (3) tick();
      chk("stall_hold", out_symbols, 8'h22);
      run = 1'b1;
      tick(); chk("stall_resume", out_symbols, 8'h33);

      // Reset pulse forwarding
      run = 1'b0; reset = 1'b1;
      tick(); chk("pulse_edge1", out_reset, 0);
      chk("pulse_clears_syms", out_symbols, 0);
      reset = 1'b0;
      tick(); chk("pulse_edge2", out_reset, 1);
      tick(); chk("pulse_edge3", out_reset, 0);

      // Stamping and multi-bit events
      run = 1'b1; in_reports = '0;
      tick(); tick();
      in_reports = 36'h000000008;
      tick();
      chk("stamp_valid", evt_if.evt_valid, 1);
      chk("stamp_cyc2", evt_if.evt_cycle, 2);
      chk("stamp_rep2", evt_if.evt_reports, 36'h000000008);
      in_reports = '0;
      tick();
      in_reports = 36'h800000001;
      tick();
      chk("stamp_head_held", evt_if.evt_cycle, 2);
      run = 1'b0; in_reports = '0;
      chk("stamp_sticky", sticky_reports, 36'h800000009);
      evt_if.evt_ready = 1'b1;
      tick();
      chk("stamp2_valid", evt_if.evt_valid, 1);
      chk("stamp_cyc4", evt_if.evt_cycle, 4);
      chk("stamp_rep4", evt_if.evt_reports, 36'h800000001);
      tick();
      chk("stamp_drained", evt_if.evt_valid, 0);
      evt_if.evt_ready = 1'b0;

      // Backpressure and overflow
      reset = 1'b1; tick(); reset = 1'b0;
      run = 1'b1; in_reports = 36'h1;
      repeat (6) tick();
      run = 1'b0; in_reports = '0;
      chk("ovf_valid", evt_if.evt_valid, 1);
      chk("ovf_head0", evt_if.evt_cycle, 0);
      chk("ovf_flag", overflow, 1);
      chk("ovf_drops", drop_count, 2);
      evt_if.evt_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         tick(); chk("ovf_drain_order", evt_if.evt_cycle, 64'(i));
      end
      tick(); chk("ovf_drain_empty", evt_if.evt_valid, 0);

      // Full with simultaneous push and pop
      evt_if.evt_ready = 1'b0; run = 1'b1; in_reports = 36'h1;
      repeat (4) tick();
      chk("full_head6", evt_if.evt_cycle, 6);
      evt_if.evt_ready = 1'b1;
      tick();
      chk("pushpop_head7", evt_if.evt_cycle, 7);
      chk("pushpop_no_drop", drop_count, 2);
      run = 1'b0; in_reports = '0;
      for (int i = 0; i < 3; i++) begin
         tick(); chk("pushpop_tail", evt_if.evt_cycle, 64'(tail_exp[i]));
      end
      tick(); chk("pushpop_empty", evt_if.evt_valid, 0);

      // clear_sticky with a same-cycle report
      run = 1'b1; in_reports = 36'h080; clear_sticky = 1'b1;
      tick();
      clear_sticky = 1'b0; run = 1'b0; in_reports = '0;
      chk("clr_sticky_bit7", sticky_reports, 36'h080);
      chk("clr_overflow", overflow, 0);
      chk("clr_drops", drop_count, 0);
      chk("clr_evt_cyc", evt_if.evt_cycle, 11);
      tick(); chk("clr_evt_drained", evt_if.evt_valid, 0);

      // Stamp wrap with continuous drain
      run = 1'b1; in_reports = 36'h2;
      for (int i = 0; i < 5; i++) begin
         tick(); chk("wrap_stamp", evt_if.evt_cycle, 64'(wrap_exp[i]));
      end
      run = 1'b0; in_reports = '0;
      tick(); chk("wrap_empty", evt_if.evt_valid, 0);

      // Drop counter saturation, then clear racing a drop
      evt_if.evt_ready = 1'b0; run = 1'b1; in_reports = 36'h1;
      repeat (9) tick();
      chk("sat_drops", drop_count, 3);
      chk("sat_overflow", overflow, 1);
      chk("sat_head", evt_if.evt_cycle, 1);
      clear_sticky = 1'b1;
      tick();
      clear_sticky = 1'b0;
      chk("clrdrop_overflow", overflow, 1);
      chk("clrdrop_count", drop_count, 1);
      chk("clrdrop_sticky", sticky_reports, 36'h1);

      // Reset mid-operation
      run = 1'b0; in_reports = '0; evt_if.evt_ready = 1'b1;
      tick(); chk("mid_head2", evt_if.evt_cycle, 2);
      reset = 1'b1; run = 1'b1; in_reports = 36'h020;
      tick();
      chk("mid_valid", evt_if.evt_valid, 0);
      chk("mid_sticky", sticky_reports, 0);
      chk("mid_overflow", overflow, 0);
      chk("mid_drops", drop_count, 0);
      reset = 1'b0; evt_if.evt_ready = 1'b0; in_reports = 36'h004;
      tick();
      chk("post_valid", evt_if.evt_valid, 1);
      chk("post_stamp0", evt_if.evt_cycle, 0);
      chk("post_reports", evt_if.evt_reports, 36'h004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
